led_pattern_sequencer: RTL and testbench

Parametrised LED-strip animation engine: holds a pattern of `PATTERN_LEDS` colours, tiles it `REPEATS` times along a WS2812-style strip, then rotates it by a programmable step and direction each frame.

- Supports continuous or N-frame runs, clean stop, and glitch-free pattern reload at frame boundaries.
- Sits between the MCU-facing register/SPI receiver and the strip data pin.
- Drives the pin through one bit-level serializer sub-module.

---
 rtl/led_pkg.sv | 39 +++
 rtl/led_word_serializer.sv | 76 +++++++
 rtl/led_pattern_sequencer.sv | 170 +++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_NEXT,
        ST_UPDATE,
        ST_GAP
    } led_state_e;

    // Widest pattern word the rotate helper handles; callers zero-extend into it.
    localparam int LED_MAX_W = 1024;

    // Rotates the low leds*colorBits bits of word by whole LEDs.
    // dir=0 moves LEDs toward the MSB (top LEDs wrap to the bottom); dir=1 the opposite way.
    function automatic logic [LED_MAX_W-1:0] led_rotate(
        input logic [LED_MAX_W-1:0] word,
        input int                   leds,
        input int                   colorBits,
        input logic [7:0]           step,
        input logic                 dir
    );
        int                   shiftLeds;
        int                   k;
        int                   w;
        logic [LED_MAX_W-1:0] mask;
        w         = leds * colorBits;
        shiftLeds = int'(step) % leds;
        if (dir) begin
            shiftLeds = (leds - shiftLeds) % leds;
        end
        k    = shiftLeds * colorBits;
        mask = {LED_MAX_W{1'b1}} >> (LED_MAX_W - w);
        return ((word << k) | (word >> (w - k))) & mask;
    endfunction

endpackage

// File: rtl/led_word_serializer.sv
// Sends one W-bit word MSB first as WS2812-style pulses: each bit is a high
// phase of T0H/T1H cycles followed by low time up to BIT_CYCLES.
module led_word_serializer #(
    parameter int W          = 144,
    parameter int BIT_CYCLES = 60,
    parameter int T0H        = 19,
    parameter int T1H        = 38
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] data_i,
    output logic         dout_o,
    output logic         done_o
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam int BW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [W-1:0]  shift_q, shift_d;
    logic          dout_q, dout_d;

    // The pin level is computed from next-state values so the output is a clean flop.
    always_comb begin
        active_d = active_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (start_i) begin
            active_d = 1'b1;
            cyc_d    = '0;
            bit_d    = '0;
            shift_d  = data_i;
        end else if (active_q) begin
            if (cyc_q == LAST_CYC) begin
                cyc_d = '0;
                if (bit_q == LAST_BIT) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = {shift_q[W-2:0], 1'b0};
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
        dout_d = active_d && (cyc_d < (shift_d[W-1] ? T1H_C : T0H_C));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            dout_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
        end
    end

    assign dout_o = dout_q;
    assign done_o = active_q && (cyc_q == LAST_CYC) && (bit_q == LAST_BIT);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED-strip animation engine: tiles a pattern word REPEATS times per frame and
// rotates it between frames, with a latch gap after every frame.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int PATTERN_LEDS = 6,
    parameter int COLOR_BITS   = 24,
    parameter int REPEATS      = 25,
    parameter int BIT_CYCLES   = 60,
    parameter int T0H          = 19,
    parameter int T1H          = 38,
    parameter int GAP_CYCLES   = 720000
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               go_i,
    input  logic                               stop_i,
    input  logic [PATTERN_LEDS*COLOR_BITS-1:0] rgb_i,
    input  logic                               rgb_load_i,
    input  logic                               dir_i,
    input  logic [7:0]                         step_i,
    input  logic [15:0]                        frames_i,
    output logic                               to_light_o,
    output logic                               busy_o,
    output logic                               frame_done_o,
    output logic [15:0]                        frame_count_o
);

    localparam int W  = PATTERN_LEDS * COLOR_BITS;
    localparam int IW = $clog2(REPEATS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(REPEATS - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    led_state_e    state_q, state_d;
    logic [W-1:0]  workWord_q, workWord_d;
    logic [W-1:0]  pendWord_q, pendWord_d;
    logic          pendValid_q, pendValid_d;
    logic          stopPend_q, stopPend_d;
    logic [IW-1:0] wordIdx_q, wordIdx_d;
    logic [GW-1:0] gapCnt_q, gapCnt_d;
    logic [15:0]   frameCount_q, frameCount_d;
    logic          serStart;
    logic          serDone;
    logic          frameDone;

    always_comb begin
        state_d      = state_q;
        workWord_d   = workWord_q;
        pendWord_d   = pendWord_q;
        pendValid_d  = pendValid_q;
        stopPend_d   = stopPend_q | stop_i;
        wordIdx_d    = wordIdx_q;
        gapCnt_d     = gapCnt_q;
        frameCount_d = frameCount_q;
        serStart     = 1'b0;
        frameDone    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stopPend_d = 1'b0;
                if (go_i) begin
                    state_d      = ST_LOAD;
                    frameCount_d = '0;
                    wordIdx_d    = '0;
                    stopPend_d   = stop_i;
                    if (pendValid_q) begin
                        workWord_d  = pendWord_q;
                        pendValid_d = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                serStart = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (serDone) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (wordIdx_q < LAST_IDX) begin
                    wordIdx_d = wordIdx_q + 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    wordIdx_d = '0;
                    state_d   = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // A freshly loaded pattern replaces the word unrotated.
                if (pendValid_q) begin
                    workWord_d  = pendWord_q;
                    pendValid_d = 1'b0;
                end else begin
                    workWord_d = W'(led_rotate(LED_MAX_W'(workWord_q), PATTERN_LEDS,
                                               COLOR_BITS, step_i, dir_i));
                end
                gapCnt_d = GAP_LOAD;
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                if (gapCnt_q == '0) begin
                    frameDone    = 1'b1;
                    frameCount_d = frameCount_q + 1'b1;
                    if (stopPend_q || stop_i ||
                        ((frames_i != '0) && (frameCount_d == frames_i))) begin
                        state_d    = ST_IDLE;
                        stopPend_d = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    gapCnt_d = gapCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Captured after any consumption above, so a load in UPDATE lands in the next frame.
        if (rgb_load_i) begin
            pendWord_d  = rgb_i;
            pendValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            workWord_q   <= '0;
            pendWord_q   <= '0;
            pendValid_q  <= 1'b0;
            stopPend_q   <= 1'b0;
            wordIdx_q    <= '0;
            gapCnt_q     <= '0;
            frameCount_q <= '0;
        end else begin
            state_q      <= state_d;
            workWord_q   <= workWord_d;
            pendWord_q   <= pendWord_d;
            pendValid_q  <= pendValid_d;
            stopPend_q   <= stopPend_d;
            wordIdx_q    <= wordIdx_d;
            gapCnt_q     <= gapCnt_d;
            frameCount_q <= frameCount_d;
        end
    end

    led_word_serializer #(
        .W          (W),
        .BIT_CYCLES (BIT_CYCLES),
        .T0H        (T0H),
        .T1H        (T1H)
    ) u_serializer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (serStart),
        .data_i  (workWord_q),
        .dout_o  (to_light_o),
        .done_o  (serDone)
    );

    assign busy_o        = (state_q != ST_IDLE);
    assign frame_done_o  = frameDone;
    assign frame_count_o = frameCount_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: per-cycle comparison against a frame-offset model,
// plus decoded-bitstream and literal timing checks for the directed scenarios.
module tb_led_pattern_sequencer;

    localparam int PL        = 2;
    localparam int CB        = 24;
    localparam int REP       = 2;
    localparam int BC        = 6;
    localparam int T0        = 2;
    localparam int T1        = 4;
    localparam int GAP       = 20;
    localparam int W         = PL * CB;
    localparam int WORD_LEN  = W * BC + 2;
    localparam int UPD_OFF   = REP * WORD_LEN;
    localparam int FRAME_LEN = UPD_OFF + 1 + GAP;

    localparam logic [W-1:0] PAT_A = 48'hFF0000_00FF00;
    localparam logic [W-1:0] PAT_R = 48'h00FF00_FF0000;
    localparam logic [W-1:0] PAT_C = 48'h0000FF_0000FF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         go = 1'b0;
    logic         stop = 1'b0;
    logic         rgbLoad = 1'b0;
    logic         dir = 1'b0;
    logic [W-1:0] rgb = '0;
    logic [7:0]   step = '0;
    logic [15:0]  frames = '0;
    logic         toLight;
    logic         busy;
    logic         frameDone;
    logic [15:0]  frameCount;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] decoded[$];

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .PATTERN_LEDS (PL),
        .COLOR_BITS   (CB),
        .REPEATS      (REP),
        .BIT_CYCLES   (BC),
        .T0H          (T0),
        .T1H          (T1),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .go_i          (go),
        .stop_i        (stop),
        .rgb_i         (rgb),
        .rgb_load_i    (rgbLoad),
        .dir_i         (dir),
        .step_i        (step),
        .frames_i      (frames),
        .to_light_o    (toLight),
        .busy_o        (busy),
        .frame_done_o  (frameDone),
        .frame_count_o (frameCount)
    );

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit doLoad, input logic [W-1:0] pat,
                                 input logic [15:0] fr, input logic [7:0] st, input logic d);
        tick(1);
        frames = fr;
        step   = st;
        dir    = d;
        if (doLoad) begin
            rgb     = pat;
            rgbLoad = 1'b1;
            tick(1);
            rgbLoad = 1'b0;
        end
        go = 1'b1;
        tick(1);
        go = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    task automatic checkFrames(input string name, input int n, input logic [W-1:0] w0,
                               input logic [W-1:0] w1, input logic [W-1:0] w2);
        logic [W-1:0] words[3];
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        checkOutput({name, "_count"}, 96'(decoded.size()), 96'(n));
        for (int i = 0; i < n; i++) begin
            if (i < decoded.size()) begin
                checkOutput($sformatf("%s_frame%0d", name, i), decoded[i], {words[i], words[i]});
            end
        end
    endtask

    function automatic logic [W-1:0] randPat();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Reference rotation done LED by LED on an array.
    function automatic logic [W-1:0] modelRotate(input logic [W-1:0] p, input logic [7:0] st,
                                                 input logic d);
        logic [CB-1:0] leds[PL];
        logic [W-1:0]  r;
        int            s;
        int            dst;
        s = int'(st) % PL;
        for (int i = 0; i < PL; i++) leds[i] = p[i*CB +: CB];
        r = '0;
        for (int i = 0; i < PL; i++) begin
            dst = d ? (i - s + PL) % PL : (i + s) % PL;
            r[dst*CB +: CB] = leds[i];
        end
        return r;
    endfunction

    // Expected pin level at a given cycle offset within a frame.
    function automatic logic expLevel(input int o, input logic [W-1:0] pat);
        int r;
        int b;
        int c;
        if (o >= UPD_OFF) return 1'b0;
        r = o % WORD_LEN;
        if (r == 0 || r == WORD_LEN - 1) return 1'b0;
        b = (r - 1) / BC;
        c = (r - 1) % BC;
        return (c < (pat[W-1-b] ? T1 : T0));
    endfunction

    logic         mValid = 1'b0;
    logic         mRun = 1'b0;
    int           mOff = 0;
    logic [W-1:0] mPat = '0;
    logic [W-1:0] mPend = '0;
    logic         mPendV = 1'b0;
    logic         mStop = 1'b0;
    logic [15:0]  mCount = '0;

    // Compare against the model, then advance it with the inputs the next edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (mValid) begin
                checkOutput("to_light", 96'(toLight), 96'(mRun ? expLevel(mOff, mPat) : 1'b0));
                checkOutput("busy", 96'(busy), 96'(mRun));
                checkOutput("frame_done", 96'(frameDone), 96'(mRun && mOff == FRAME_LEN - 1));
                checkOutput("frame_count", 96'(frameCount), 96'(mCount));
            end
            if (rst) begin
                mValid = 1'b1;
                mRun   = 1'b0;
                mOff   = 0;
                mPat   = '0;
                mPend  = '0;
                mPendV = 1'b0;
                mStop  = 1'b0;
                mCount = '0;
            end else begin
                if (!mRun) begin
                    mStop = 1'b0;
                    if (go) begin
                        mRun   = 1'b1;
                        mOff   = 0;
                        mCount = '0;
                        mStop  = stop;
                        if (mPendV) begin
                            mPat   = mPend;
                            mPendV = 1'b0;
                        end
                    end
                end else begin
                    mStop = mStop | stop;
                    if (mOff == UPD_OFF) begin
                        if (mPendV) begin
                            mPat   = mPend;
                            mPendV = 1'b0;
                        end else begin
                            mPat = modelRotate(mPat, step, dir);
                        end
                        mOff++;
                    end else if (mOff == FRAME_LEN - 1) begin
                        mCount = mCount + 16'd1;
                        if (mStop || (frames != 16'd0 && mCount == frames)) begin
                            mRun  = 1'b0;
                            mStop = 1'b0;
                        end else begin
                            mOff = 0;
                        end
                    end else begin
                        mOff++;
                    end
                end
                if (rgbLoad) begin
                    mPend  = rgb;
                    mPendV = 1'b1;
                end
            end
        end
    end

    // Decodes the pin back into frames of bits by high-pulse length.
    initial begin
        int             hi;
        int             nb;
        logic [2*W-1:0] bits;
        hi   = 0;
        nb   = 0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi   = 0;
                nb   = 0;
                bits = '0;
            end else begin
                if (toLight === 1'b1) begin
                    hi++;
                end else if (hi > 0) begin
                    bits = {bits[2*W-2:0], (hi == T1)};
                    nb++;
                    hi = 0;
                end
                if (frameDone === 1'b1 && nb > 0) begin
                    decoded.push_back(bits);
                    nb   = 0;
                    bits = '0;
                end
            end
        end
    end

    initial begin
        int off;
        int n;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 96'(busy), 96'd0);
        checkOutput("reset_to_light", 96'(toLight), 96'd0);
        checkOutput("reset_frame_count", 96'(frameCount), 96'd0);
        checkOutput("reset_frame_done", 96'(frameDone), 96'd0);

        $display("[TB] single frame");
        decoded.delete();
        applyStimulus(1'b1, PAT_A, 16'd1, 8'd0, 1'b0);
        @(negedge clk);
        checkOutput("t1_load_low", 96'(toLight), 96'd0);
        checkOutput("t1_busy", 96'(busy), 96'd1);
        @(negedge clk);
        checkOutput("t1_first_rise", 96'(toLight), 96'd1);
        off = 1;
        while (frameDone !== 1'b1 && off < 2000) begin
            @(negedge clk);
            off++;
        end
        checkOutput("t1_frame_len", 96'(off), 96'd600);
        waitIdle("t1_idle", 50);
        checkOutput("t1_frame_count", 96'(frameCount), 96'd1);
        checkFrames("t1", 1, PAT_A, PAT_A, PAT_A);

        $display("[TB] three frames rotate left");
        decoded.delete();
        applyStimulus(1'b0, '0, 16'd3, 8'd1, 1'b0);
        waitIdle("t2_idle", 3 * FRAME_LEN + 50);
        checkOutput("t2_frame_count", 96'(frameCount), 96'd3);
        checkFrames("t2", 3, PAT_A, PAT_R, PAT_A);

        $display("[TB] rotate right with step modulo");
        decoded.delete();
        applyStimulus(1'b0, '0, 16'd2, 8'd3, 1'b1);
        waitIdle("t3a_idle", 2 * FRAME_LEN + 50);
        checkFrames("t3a", 2, PAT_R, PAT_A, PAT_A);
        decoded.delete();
        applyStimulus(1'b0, '0, 16'd2, 8'd0, 1'b1);
        waitIdle("t3b_idle", 2 * FRAME_LEN + 50);
        checkFrames("t3b", 2, PAT_R, PAT_R, PAT_R);

        $display("[TB] reload mid-frame");
        decoded.delete();
        applyStimulus(1'b0, '0, 16'd2, 8'd1, 1'b0);
        tick(100);
        rgb     = PAT_C;
        rgbLoad = 1'b1;
        tick(1);
        rgbLoad = 1'b0;
        waitIdle("t4_idle", 2 * FRAME_LEN + 50);
        checkFrames("t4", 2, PAT_R, PAT_C, PAT_C);

        $display("[TB] continuous run with stop");
        decoded.delete();
        applyStimulus(1'b0, '0, 16'd0, 8'd1, 1'b0);
        tick(200);
        go = 1'b1;
        tick(1);
        go = 1'b0;
        tick(FRAME_LEN);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        waitIdle("t5_idle", 2 * FRAME_LEN);
        checkOutput("t5_frame_count", 96'(frameCount), 96'd2);
        checkFrames("t5", 2, PAT_C, PAT_C, PAT_C);

        $display("[TB] reset mid-bit");
        applyStimulus(1'b1, PAT_A, 16'd0, 8'd0, 1'b0);
        n = 0;
        while (toLight !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput("t6_high_before_reset", 96'(toLight), 96'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_to_light", 96'(toLight), 96'd0);
        checkOutput("t6_busy", 96'(busy), 96'd0);
        checkOutput("t6_frame_count", 96'(frameCount), 96'd0);
        checkOutput("t6_frame_done", 96'(frameDone), 96'd0);
        decoded.delete();
        applyStimulus(1'b1, PAT_A, 16'd1, 8'd0, 1'b0);
        waitIdle("t6_idle", FRAME_LEN + 50);
        checkFrames("t6", 1, PAT_A, PAT_A, PAT_A);

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(1'b1, randPat(), 16'($urandom_range(1, 3)),
                          8'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            n = 0;
            while (busy === 1'b1 && n < 4 * FRAME_LEN + 100) begin
                rgbLoad = ($urandom_range(0, 399) == 0);
                if (rgbLoad) rgb = randPat();
                stop = ($urandom_range(0, 1999) == 0);
                go   = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 49) == 0) begin
                    step = 8'($urandom_range(0, 255));
                    dir  = 1'($urandom_range(0, 1));
                end
                frames = 16'($urandom_range(1, 3));
                tick(1);
                rgbLoad = 1'b0;
                stop    = 1'b0;
                go      = 1'b0;
                n++;
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL random_run%0d: busy=%0b after %0d cycles, expected 0", r, busy, n);
            end
        end

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
